mem_arbiter: RTL

- Two-master, one-slave arbiter sharing the single data-memory port between IFU (instruction fetch, read-only) and LSU (load/store).
- Sits between the pipeline front/back ends and the memory/bus slave.
- Accepts one request at a time, registers it, issues it to memory and routes the response back to the owner.
- LSU has priority; a starvation counter guarantees IFU forward progress.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/arb_prio_starve.sv | 38 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, MemOP encodings and FSM state type for the IFU/LSU memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned RegWidth = 64;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LD  = 3'b011;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;
  localparam logic [2:0] MEMOP_LWU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP
  } arb_state_e;

endpackage

// File: rtl/arb_prio_starve.sv
// LSU-priority grant logic with a saturating IFU starvation counter.
module arb_prio_starve #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  input  logic i_accept,
  output logic o_grant_ifu,
  output logic o_grant_lsu
);

  localparam logic [3:0] CntMax = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_starved;

  always_comb begin
    w_starved   = (r_starve_cnt == CntMax);
    o_grant_ifu = i_ifu_valid & (~i_lsu_valid | w_starved);
    o_grant_lsu = i_lsu_valid & ~o_grant_ifu;
  end

  // Only losses suffered while IFU was actually waiting count towards starvation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (i_accept) begin
      if (o_grant_ifu) begin
        r_starve_cnt <= '0;
      end else if (o_grant_lsu && i_ifu_valid && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one memory port arbiter: grant, register, issue, route response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = RegWidth,
  parameter int unsigned DATA_W     = RegWidth,
  parameter logic [2:0]  IFU_MEMOP  = MEMOP_LWU,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              ifu_resp_ready,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_we,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_memop,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  input  logic              lsu_resp_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_memop,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              mem_resp_ready,
  output logic              owner
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_memop;

  logic w_idle;
  logic w_wait;
  logic w_accept;
  logic w_grant_ifu;
  logic w_grant_lsu;

  // Grants are suppressed while reset is held so no handshake is seen during reset.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_wait   = (r_state == ST_WAIT_RESP);
  assign w_accept = w_idle & rst & (ifu_req_valid | lsu_req_valid);

  arb_prio_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk         (clk),
    .rst         (rst),
    .i_ifu_valid (ifu_req_valid),
    .i_lsu_valid (lsu_req_valid),
    .i_accept    (w_accept),
    .o_grant_ifu (w_grant_ifu),
    .o_grant_lsu (w_grant_lsu)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        ifu_req_ready = rst & w_grant_ifu;
        lsu_req_ready = rst & w_grant_lsu;
        if (w_accept) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        mem_resp_ready = r_owner ? lsu_resp_ready : ifu_resp_ready;
        ifu_resp_valid = ~r_owner & mem_resp_valid;
        lsu_resp_valid = r_owner & mem_resp_valid;
        if (mem_resp_valid && mem_resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_memop <= '0;
    end else if (w_accept) begin
      r_owner <= w_grant_lsu;
      if (w_grant_lsu) begin
        r_addr  <= lsu_addr;
        r_we    <= lsu_we;
        r_wdata <= lsu_wdata;
        r_memop <= lsu_memop;
      end else begin
        r_addr  <= ifu_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_memop <= IFU_MEMOP;
      end
    end
  end

  assign mem_addr      = r_addr;
  assign mem_we        = r_we;
  assign mem_wdata     = r_wdata;
  assign mem_memop     = r_memop;
  assign owner         = r_owner;
  assign ifu_resp_data = mem_resp_data;
  assign lsu_resp_data = mem_resp_data;

  logic w_unused;
  assign w_unused = w_wait;

endmodule
